edge_event_monitor: RTL and testbench
=====================================

EDGE_EVENT_MONITOR -- requirements
Module: edge_event_monitor

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning the number of independent monitored channels (1..32).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning the per-channel event counter width (2..16).
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth (0..3; 0 = no synchroniser).
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; all logic is on its posedge.
REQ-005 The module SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-006 The module SHALL have port sig_in, input, NUM_CH, meaning the monitored levels, one bit per channel.
REQ-007 The module SHALL have port qual_en, input, NUM_CH, meaning the per-channel qualifier; a detected edge counts only while its bit is 1.
REQ-008 The module SHALL have port mode, input, 2*NUM_CH, meaning the per-channel edge mode: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 The module SHALL have port ack, input, NUM_CH, meaning a write-1-to-clear of the pending flag.
REQ-010 The module SHALL have port cnt_clr, input, NUM_CH, meaning a synchronous clear of the channel counter.
REQ-011 The module SHALL have port irq_mask, input, NUM_CH, meaning the interrupt enable per channel.
REQ-012 The module SHALL have port event_pulse, output, NUM_CH, meaning a one-cycle strobe per qualified edge.
REQ-013 The module SHALL have port event_pending, output, NUM_CH, meaning a sticky flag that is set by an event and cleared by ack.
REQ-014 The module SHALL have port event_cnt, output, NUM_CH*CNT_W, meaning the saturating qualified-event count per channel.
REQ-015 The module SHALL have port irq, output, 1, meaning the OR over channels of event_pending & irq_mask.

Function
REQ-016 Each channel SHALL pass sig_in through SYNC_STAGES flops, then compare the synchroniser output to a one-cycle-delayed copy (prev).
REQ-017 Rising edge = sync&~prev; falling = ~sync&prev; the edge SHALL be accepted when it matches mode and qual_en=1 in the same cycle.
REQ-018 An edge SHALL be dropped, not deferred, when qual_en=0 or mode=00.
REQ-019 event_pulse SHALL assert exactly SYNC_STAGES+1 clk edges after the edge at which the new sig_in level is first sampled, for exactly one cycle.
REQ-020 prev SHALL update every cycle regardless of mode or qual_en, so a mode change never produces a stale edge.
REQ-021 A mode change SHALL take effect on the cycle it is applied (no extra latency).
REQ-022 event_pending SHALL be set in the same cycle that event_pulse asserts, and remain set until ack.
REQ-023 When ack and a new event occur in the same cycle, event_pending SHALL remain 1 (the event wins).
REQ-024 event_cnt SHALL increment by 1 per accepted event and SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-025 When cnt_clr and an event occur in the same cycle, event_cnt SHALL become 1; cnt_clr alone SHALL set it to 0.
REQ-026 irq SHALL be combinational from the registered event_pending and irq_mask, with no added latency.
REQ-027 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be recorded.

Reset
REQ-028 While reset=1, the synchroniser flops, prev, event_pulse, event_pending and event_cnt SHALL be 0, and irq SHALL be 0.
REQ-029 Edge detection SHALL be suppressed for SYNC_STAGES+1 cycles after reset deasserts (priming), so that a high sig_in held through reset yields no event.
REQ-030 Reset asserted mid-operation SHALL abort any in-flight edge, with no event_pulse in the cycle after reset is sampled.

Structure
REQ-031 Package edge_mon_pkg SHALL hold the edge_mode_e enum (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the bounds for SYNC_STAGES and CNT_W.
REQ-032 Per-channel logic SHALL be the sub-module edge_mon_chan, instantiated NUM_CH times by a generate loop; the top level contains only the generate loop and the irq reduction.

Verification
REQ-033 The bench SHALL cover: SYNC_STAGES=2, ch0 mode=01, qual=1, sig_in 0->1 sampled at edge k -> event_pulse[0]=1 only in the cycle after edge k+3, pending[0]=1, cnt[0]=1.
REQ-034 The bench SHALL cover: mode=11, qual_en toggled low during the falling edge, sig_in pulses high for 3 cycles -> rise counted, fall dropped, cnt=1.
REQ-035 The bench SHALL cover: sig_in=1 held through reset, reset released -> no event_pulse and cnt=0 after priming.
REQ-036 The bench SHALL cover: CNT_W=2 with 5 rising edges -> cnt saturates at 3; then cnt_clr together with a 6th edge -> cnt=1.
REQ-037 The bench SHALL cover: ack[1] issued in the same cycle as a new ch1 event -> pending[1] stays 1; ack alone next cycle -> pending[1]=0; with irq_mask=0b0010, irq follows pending[1].
REQ-038 The bench SHALL cover: reset pulsed for 1 cycle between the sig_in edge and the expected pulse -> no pulse, and all outputs are 0 the cycle after reset is sampled.

Source files
------------

// File: rtl/edge_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_mon_pkg
// Description : Shared types, parameter bounds and edge-match helper for the
//               edge event monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_mon_pkg;

    // Per-channel edge selection, two bits per channel on the mode bus.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    // Legal parameter ranges.
    localparam int c_num_ch_min      = 1;
    localparam int c_num_ch_max      = 32;
    localparam int c_cnt_w_min       = 2;
    localparam int c_cnt_w_max       = 16;
    localparam int c_sync_stages_min = 0;
    localparam int c_sync_stages_max = 3;

    // Priming counter must hold c_sync_stages_max + 1.
    localparam int c_prime_w = 3;

    // True when a detected rise/fall is one the selected mode listens for.
    function automatic logic edge_match(input edge_mode_e m, input logic rise, input logic fall);
        return (rise && (m == MODE_RISE || m == MODE_BOTH)) ||
               (fall && (m == MODE_FALL || m == MODE_BOTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_mon_chan.sv
`default_nettype none
// ============================================================================
// Module      : edge_mon_chan
// Description : One monitored channel: input synchroniser, edge detector with
//               post-reset priming, qualification, sticky pending flag and
//               saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_mon_chan
    import edge_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             qual_en,
    input  edge_mode_e       mode,
    input  logic             ack,
    input  logic             cnt_clr,
    output logic             event_pulse,
    output logic             event_pending,
    output logic [CNT_W-1:0] event_cnt
);

    localparam logic [c_prime_w-1:0] c_prime_init = c_prime_w'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]     c_cnt_max    = {CNT_W{1'b1}};

    logic                 w_sync;
    logic                 w_primed;
    logic                 w_accept;
    logic [c_prime_w-1:0] r_prime;
    logic                 r_prev;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_pulse;
    logic                 r_pending;
    logic [CNT_W-1:0]     r_cnt;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Shift the raw level through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= sig_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_sync = r_sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_sync = sig_in;
        end
    endgenerate

    // Edges are ignored until the synchroniser and prev hold post-reset data,
    // so a level held high through reset is not mistaken for a rise.
    assign w_primed = (r_prime == '0);

    // Priming countdown, prev tracking and registered raw edge detection;
    // prev follows the sync output every cycle independent of mode/qualifier.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prime <= c_prime_init;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            if (!w_primed) begin
                r_prime <= r_prime - 1'b1;
            end
            r_prev <= w_sync;
            r_rise <= w_primed &  w_sync & ~r_prev;
            r_fall <= w_primed & ~w_sync &  r_prev;
        end
    end

    // Mode and qualifier are applied combinationally, so a change acts at once
    // and an unqualified edge is simply lost.
    assign w_accept = edge_match(mode, r_rise, r_fall) & qual_en;

    // Event strobe, sticky pending (new event beats ack) and saturating count
    // (a clear coinciding with an event leaves a count of one).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_pulse   <= w_accept;
            r_pending <= w_accept | (r_pending & ~ack);
            if (cnt_clr) begin
                r_cnt <= w_accept ? CNT_W'(1) : '0;
            end else if (w_accept && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign event_pulse   = r_pulse;
    assign event_pending = r_pending;
    assign event_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: rtl/edge_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_monitor
// Description : Multi-channel edge event monitor; replicates edge_mon_chan per
//               channel and ORs masked pending flags into one interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_monitor
    import edge_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic [NUM_CH-1:0]       qual_en,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       ack,
    input  logic [NUM_CH-1:0]       cnt_clr,
    input  logic [NUM_CH-1:0]       irq_mask,
    output logic [NUM_CH-1:0]       event_pulse,
    output logic [NUM_CH-1:0]       event_pending,
    output logic [NUM_CH*CNT_W-1:0] event_cnt,
    output logic                    irq
);

    generate
        if (NUM_CH < c_num_ch_min || NUM_CH > c_num_ch_max ||
            CNT_W < c_cnt_w_min || CNT_W > c_cnt_w_max ||
            SYNC_STAGES < c_sync_stages_min || SYNC_STAGES > c_sync_stages_max) begin : g_bad_params
            $error("edge_event_monitor: parameter out of range");
        end

        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            edge_mon_chan #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .clk           (clk),
                .reset         (reset),
                .sig_in        (sig_in[g]),
                .qual_en       (qual_en[g]),
                .mode          (edge_mode_e'(mode[2*g +: 2])),
                .ack           (ack[g]),
                .cnt_clr       (cnt_clr[g]),
                .event_pulse   (event_pulse[g]),
                .event_pending (event_pending[g]),
                .event_cnt     (event_cnt[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Interrupt is a pure function of registered pending flags and the mask.
    assign irq = |(event_pending & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_edge_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_monitor
// Description : Self-checking bench for edge_event_monitor (4 channels,
//               2-bit counters, 2-stage synchroniser).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_monitor;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 2;
    localparam int SYNC_STAGES = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       sig_in;
    logic [NUM_CH-1:0]       qual_en;
    logic [2*NUM_CH-1:0]     mode;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       cnt_clr;
    logic [NUM_CH-1:0]       irq_mask;
    logic [NUM_CH-1:0]       event_pulse;
    logic [NUM_CH-1:0]       event_pending;
    logic [NUM_CH*CNT_W-1:0] event_cnt;
    logic                    irq;

    edge_event_monitor #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sig_in        (sig_in),
        .qual_en       (qual_en),
        .mode          (mode),
        .ack           (ack),
        .cnt_clr       (cnt_clr),
        .irq_mask      (irq_mask),
        .event_pulse   (event_pulse),
        .event_pending (event_pending),
        .event_cnt     (event_cnt),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] sig;
        logic [3:0] qual;
        logic [7:0] md;
        logic [3:0] ak;
        logic [3:0] clr;
        logic [3:0] msk;
        logic [3:0] e_pulse;
        logic [3:0] e_pend;
        logic [7:0] e_cnt;
        logic       e_irq;
    } vec_t;

    vec_t       tbl[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] m_cnt[4];
    logic [3:0] m_pend;

    task automatic add(input logic rst, input logic [3:0] sig, input logic [3:0] qual,
                       input logic [7:0] md, input logic [3:0] ak, input logic [3:0] clr,
                       input logic [3:0] msk, input logic [3:0] ep, input logic [3:0] epd,
                       input logic [7:0] ec, input logic ei);
        vec_t v;
        v = '{rst, sig, qual, md, ak, clr, msk, ep, epd, ec, ei};
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ep, input logic [3:0] epd,
                         input logic [7:0] ec, input logic ei);
        n_vec++;
        if ({event_pulse, event_pending, event_cnt, irq} !== {ep, epd, ec, ei}) begin
            n_err++;
            $display("FAIL %s: got pulse=%b pend=%b cnt=%h irq=%b, want pulse=%b pend=%b cnt=%h irq=%b",
                     name, event_pulse, event_pending, event_cnt, irq, ep, epd, ec, ei);
        end
    endtask

    function automatic logic [7:0] pack_cnt();
        return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    endfunction

    task automatic check_model(input string name, input logic [3:0] ep);
        check(name, ep, m_pend, pack_cnt(), |(m_pend & irq_mask));
    endtask

    // Rising edge on every channel in chs: high two cycles, low four.  The
    // accept cycle is the fourth (k+3); clr_at/ack_at are driven only there.
    task automatic run_edge(input logic [3:0] chs, input logic [3:0] clr_at,
                            input logic [3:0] ack_at, input string name);
        for (int i = 0; i < 6; i++) begin
            sig_in  = (i < 2) ? (sig_in | chs) : (sig_in & ~chs);
            cnt_clr = (i == 3) ? clr_at : 4'h0;
            ack     = (i == 3) ? ack_at : 4'h0;
            tick();
            if (i == 3) begin
                for (int c = 0; c < 4; c++) begin
                    if (chs[c]) begin
                        m_pend[c] = 1'b1;
                        m_cnt[c]  = clr_at[c] ? 2'd1 : ((m_cnt[c] == 2'd3) ? 2'd3 : 2'(m_cnt[c] + 2'd1));
                    end else begin
                        if (clr_at[c]) m_cnt[c] = 2'd0;
                        if (ack_at[c]) m_pend[c] = 1'b0;
                    end
                end
            end
            check_model(name, (i == 3) ? chs : 4'h0);
        end
        cnt_clr = 4'h0;
        ack     = 4'h0;
    endtask

    initial begin
        reset = 1'b1; sig_in = '0; qual_en = '0; mode = '0;
        ack = '0; cnt_clr = '0; irq_mask = '0;

        // Ch0 table: held-high through reset, 0->1 latency, ack, mode 11 with
        // fall dropped by qualifier, irq via mask.
        add(1, 4'h1, 4'h1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        add(1, 4'h1, 4'h1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) add(0, 4'h1, 4'h1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) add(0, 4'h0, 4'h1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(0, 4'h1, 4'h1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        add(0, 4'h1, 4'h1, 8'h01, 0, 0, 0, 4'h1, 4'h1, 8'h01, 0);
        add(0, 4'h1, 4'h1, 8'h01, 0, 0, 0, 0, 4'h1, 8'h01, 0);
        add(0, 4'h1, 4'h1, 8'h01, 4'h1, 0, 0, 0, 0, 8'h01, 0);
        for (int i = 0; i < 4; i++) add(0, 4'h0, 4'h1, 8'h01, 0, 0, 0, 0, 0, 8'h01, 0);
        add(0, 4'h0, 4'h1, 8'h01, 0, 4'h1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(0, 4'h1, 4'h1, 8'h03, 0, 0, 0, 0, 0, 8'h00, 0);
        add(0, 4'h0, 4'h1, 8'h03, 0, 0, 0, 4'h1, 4'h1, 8'h01, 0);
        for (int i = 0; i < 3; i++) add(0, 4'h0, 4'h0, 8'h03, 0, 0, 0, 0, 4'h1, 8'h01, 0);
        add(0, 4'h0, 4'h1, 8'h03, 0, 0, 0, 0, 4'h1, 8'h01, 0);
        add(0, 4'h0, 4'h1, 8'h03, 0, 0, 4'h1, 0, 4'h1, 8'h01, 1);
        add(0, 4'h0, 4'h1, 8'h03, 4'h1, 0, 4'h1, 0, 0, 8'h01, 0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; sig_in = tbl[i].sig; qual_en = tbl[i].qual;
            mode = tbl[i].md; ack = tbl[i].ak; cnt_clr = tbl[i].clr; irq_mask = tbl[i].msk;
            tick();
            check($sformatf("vec[%0d]", i), tbl[i].e_pulse, tbl[i].e_pend, tbl[i].e_cnt, tbl[i].e_irq);
        end

        // Clean restart for the model-tracked sequences.
        reset = 1'b1; sig_in = '0; ack = '0; cnt_clr = '0; irq_mask = '0;
        mode = 8'h55; qual_en = 4'hF;
        m_pend = '0;
        for (int c = 0; c < 4; c++) m_cnt[c] = 2'd0;
        tick(); tick();
        check_model("reset_b", 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_model("prime_b", 4'h0);
        end

        // Saturation at 3, then clear coinciding with a sixth edge.
        for (int n = 0; n < 5; n++) run_edge(4'h1, 4'h0, 4'h0, "sat");
        run_edge(4'h1, 4'h1, 4'h0, "clr_with_edge");
        cnt_clr = 4'h1;
        tick();
        m_cnt[0] = 2'd0;
        check_model("clr_alone", 4'h0);
        cnt_clr = 4'h0;

        // Ch1 ack racing a new event, then ack alone; irq follows pending[1].
        irq_mask = 4'b0010;
        run_edge(4'h2, 4'h0, 4'h0, "ch1_first");
        run_edge(4'h2, 4'h0, 4'h2, "ack_vs_event");
        ack = 4'h2;
        tick();
        m_pend[1] = 1'b0;
        check_model("ack_alone", 4'h0);
        ack = 4'h0;

        // Simultaneous events on every channel.
        run_edge(4'hF, 4'h0, 4'h0, "all_ch");

        // Reset between the sampled edge and its pulse aborts the event.
        sig_in = 4'h1;
        tick();
        check_model("pre_abort", 4'h0);
        reset = 1'b1;
        tick();
        m_pend = '0;
        for (int c = 0; c < 4; c++) m_cnt[c] = 2'd0;
        check_model("in_reset", 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_model("post_abort", 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
